// File: rtl/rssb_exec_if.sv
// rtl/rssb_exec_if.sv - operand/result bundle between the memory stage and the rssb execute stage
interface rssb_exec_if #(
  parameter int BW = 1,
  parameter int NS = 4,
  parameter int SW = 2
);
  logic          ena;
  logic [BW-1:0] data [1:0];
  logic          flush;
  logic [BW-1:0] result;
  logic          res_vld;
  logic          flag;
  logic          flag_vld;
  logic          zero;
  logic          last;
  logic [SW-1:0] cnt;

  modport master (
    output ena, data, flush,
    input  result, res_vld, flag, flag_vld, zero, last, cnt
  );

  modport slave (
    input  ena, data, flush,
    output result, res_vld, flag, flag_vld, zero, last, cnt
  );
endinterface

// File: rtl/rssb_exec.sv
// rtl/rssb_exec.sv - bit-serial reverse-subtract-and-skip-if-borrow execute stage
module rssb_exec #(
  parameter int BW = 1,
  parameter int NS = 4,
  parameter int SW = 2
) (
  input  logic       clk,
  input  logic       rst,
  rssb_exec_if.slave bus
);
  logic [BW-1:0] r_result;
  logic          r_res_vld;
  logic          r_flag;
  logic          r_flag_vld;
  logic          r_zero;
  logic          r_last;
  logic [SW-1:0] r_cnt;
  logic          r_brw;
  logic          r_zacc;

  logic [BW:0]   w_sub;
  logic [BW-1:0] w_diff;
  logic          w_bout;
  logic          w_dz;
  logic          w_final;

  // Borrow-in is folded into the same BW+1 bit subtraction; the MSB is borrow-out.
  assign w_sub   = {1'b0, bus.data[1]} - {1'b0, bus.data[0]} - {{BW{1'b0}}, r_brw};
  assign w_diff  = w_sub[BW-1:0];
  assign w_bout  = w_sub[BW];
  assign w_dz    = (w_diff == '0);
  assign w_final = (r_cnt == SW'(NS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_result   <= '0;
      r_res_vld  <= 1'b0;
      r_flag     <= 1'b0;
      r_flag_vld <= 1'b0;
      r_zero     <= 1'b0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_brw      <= 1'b0;
      r_zacc     <= 1'b1;
    end else if (bus.flush) begin
      r_res_vld  <= 1'b0;
      r_flag_vld <= 1'b0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_brw      <= 1'b0;
      r_zacc     <= 1'b1;
    end else if (bus.ena) begin
      r_result  <= w_diff;
      r_res_vld <= 1'b1;
      r_last    <= w_final;
      if (w_final) begin
        r_flag     <= w_bout;
        r_zero     <= r_zacc & w_dz;
        r_flag_vld <= 1'b1;
        r_cnt      <= '0;
        r_brw      <= 1'b0;
        r_zacc     <= 1'b1;
      end else begin
        r_brw      <= w_bout;
        r_zacc     <= r_zacc & w_dz;
        r_cnt      <= r_cnt + SW'(1);
        r_flag_vld <= 1'b0;
      end
    end else begin
      r_res_vld  <= 1'b0;
      r_flag_vld <= 1'b0;
      r_last     <= 1'b0;
    end
  end

  assign bus.result   = r_result;
  assign bus.res_vld  = r_res_vld;
  assign bus.flag     = r_flag;
  assign bus.flag_vld = r_flag_vld;
  assign bus.zero     = r_zero;
  assign bus.last     = r_last;
  assign bus.cnt      = r_cnt;
endmodule

// File: tb/tb_rssb_exec.sv
// tb/tb_rssb_exec.sv - directed self-checking bench for rssb_exec
module tb_rssb_exec;
  localparam int BW = 1;
  localparam int NS = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  rssb_exec_if #(.BW(BW), .NS(NS), .SW(SW)) bus ();

  rssb_exec #(.BW(BW), .NS(NS), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Drives one slice, then checks the registered outputs one cycle later.
  task automatic do_slice(input string tag, input logic m, input logic s,
                          input logic er, input logic elast, input int ecnt);
    bus.ena     = 1'b1;
    bus.data[1] = m;
    bus.data[0] = s;
    @(posedge clk);
    #1;
    bus.ena = 1'b0;
    check({tag, ".result"}, 32'(bus.result), 32'(er));
    check({tag, ".res_vld"}, 32'(bus.res_vld), 32'd1);
    check({tag, ".last"}, 32'(bus.last), 32'(elast));
    check({tag, ".flag_vld"}, 32'(bus.flag_vld), 32'(elast));
    check({tag, ".cnt"}, 32'(bus.cnt), 32'(ecnt));
  endtask

  task automatic idle(input string tag, input int n, input int ecnt);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check({tag, ".idle_res_vld"}, 32'(bus.res_vld), 32'd0);
      check({tag, ".idle_flag_vld"}, 32'(bus.flag_vld), 32'd0);
      check({tag, ".idle_last"}, 32'(bus.last), 32'd0);
      check({tag, ".idle_cnt"}, 32'(bus.cnt), 32'(ecnt));
    end
  endtask

  // Full word, LSB slice first; optional idle gap after slice gap_at.
  task automatic run_word(input string tag, input logic [3:0] m, input logic [3:0] s,
                          input logic [3:0] er, input logic ef, input logic ez,
                          input int gap_at, input int gap_len);
    for (int i = 0; i < NS; i++) begin
      do_slice($sformatf("%s.s%0d", tag, i), m[i], s[i], er[i], (i == NS - 1), (i + 1) % NS);
      if (i == gap_at) idle(tag, gap_len, i + 1);
    end
    check({tag, ".flag"}, 32'(bus.flag), 32'(ef));
    check({tag, ".zero"}, 32'(bus.zero), 32'(ez));
    @(posedge clk);
    #1;
    check({tag, ".flag_hold"}, 32'(bus.flag), 32'(ef));
    check({tag, ".zero_hold"}, 32'(bus.zero), 32'(ez));
    check({tag, ".flag_vld_drop"}, 32'(bus.flag_vld), 32'd0);
  endtask

  task automatic do_flush(input string tag, input logic eres, input logic ef, input logic ez);
    bus.flush   = 1'b1;
    bus.ena     = 1'b1;
    bus.data[1] = 1'b0;
    bus.data[0] = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.ena   = 1'b0;
    check({tag, ".res_vld"}, 32'(bus.res_vld), 32'd0);
    check({tag, ".flag_vld"}, 32'(bus.flag_vld), 32'd0);
    check({tag, ".last"}, 32'(bus.last), 32'd0);
    check({tag, ".cnt"}, 32'(bus.cnt), 32'd0);
    check({tag, ".result_hold"}, 32'(bus.result), 32'(eres));
    check({tag, ".flag_hold"}, 32'(bus.flag), 32'(ef));
    check({tag, ".zero_hold"}, 32'(bus.zero), 32'(ez));
  endtask

  initial begin
    bus.ena     = 1'b0;
    bus.flush   = 1'b0;
    bus.data[0] = '0;
    bus.data[1] = '0;
    rst         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.result", 32'(bus.result), 32'd0);
    check("rst.res_vld", 32'(bus.res_vld), 32'd0);
    check("rst.flag", 32'(bus.flag), 32'd0);
    check("rst.flag_vld", 32'(bus.flag_vld), 32'd0);
    check("rst.zero", 32'(bus.zero), 32'd0);
    check("rst.last", 32'(bus.last), 32'd0);
    check("rst.cnt", 32'(bus.cnt), 32'd0);
    rst = 1'b1;
    idle("post_rst", 1, 0);

    // 5-3: m=0101 s=0011 -> diff 0010, no borrow
    run_word("w53", 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, -1, 0);
    // 3-5: m=0011 s=0101 -> diff 1110, borrow out
    run_word("w35", 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, -1, 0);
    // 6-6 with a two-cycle gap between slices 1 and 2
    run_word("w66gap", 4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b1, 1, 2);

    // Flush after two slices of 3-5; flag/zero keep the 6-6 word's values
    do_slice("fl2.s0", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    do_slice("fl2.s1", 1'b1, 1'b0, 1'b1, 1'b0, 2);
    do_flush("fl2", 1'b1, 1'b0, 1'b1);
    run_word("fl2.w53", 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, -1, 0);

    // Flush after three slices of 3-5, where the pending borrow is 1
    do_slice("fl3.s0", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    do_slice("fl3.s1", 1'b1, 1'b0, 1'b1, 1'b0, 2);
    do_slice("fl3.s2", 1'b0, 1'b1, 1'b1, 1'b0, 3);
    do_flush("fl3", 1'b1, 1'b0, 1'b0);
    run_word("fl3.w66", 4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b1, -1, 0);

    // Reset mid-word with borrow pending
    run_word("pre.w35", 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, -1, 0);
    do_slice("rmw.s0", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    do_slice("rmw.s1", 1'b1, 1'b0, 1'b1, 1'b0, 2);
    do_slice("rmw.s2", 1'b0, 1'b1, 1'b1, 1'b0, 3);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rmw.cnt", 32'(bus.cnt), 32'd0);
    check("rmw.res_vld", 32'(bus.res_vld), 32'd0);
    check("rmw.flag", 32'(bus.flag), 32'd0);
    check("rmw.result", 32'(bus.result), 32'd0);
    run_word("rmw.w66", 4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
